iob2axil: RTL
=============

Name: iob2axil

Overview:
- Stateful bridge: IOb slave port in, AXI4-Lite master port out.
- Sits downstream of an IOb master (CPU or interconnect) and drives an AXI-Lite peripheral or interconnect.
- One outstanding transaction at a time, with registered outputs on both sides.
- Waits for full AXI responses, including B and R, before accepting the next IOb request.

Parameters:
- AXIL_ADDR_W, 32, AXI-Lite address width
- AXIL_DATA_W, 32, AXI-Lite data width
- ADDR_W, AXIL_ADDR_W, IOb address width (must be <= AXIL_ADDR_W; zero-extended)
- DATA_W, AXIL_DATA_W, IOb data width (must equal AXIL_DATA_W)

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; state and registers update only when 1
- arst_i  in  1  asynchronous active-high reset
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero = write, zero = read
- iob_rvalid_o  out  1  read data valid, one-cycle pulse
- iob_rdata_o  out  DATA_W  read data
- iob_ready_o  out  1  request accepted when high with avalid
- axil_awaddr_o / axil_awprot_o / axil_awvalid_o  out  AXIL_ADDR_W/3/1  write address channel
- axil_awready_i  in  1
- axil_wdata_o / axil_wstrb_o / axil_wvalid_o  out  AXIL_DATA_W/AXIL_DATA_W/8/1  write data channel
- axil_wready_i  in  1
- axil_bresp_i / axil_bvalid_i  in  2/1;  axil_bready_o  out  1  write response channel
- axil_araddr_o / axil_arprot_o / axil_arvalid_o  out  AXIL_ADDR_W/3/1  read address channel
- axil_arready_i  in  1
- axil_rdata_i / axil_rresp_i / axil_rvalid_i  in  AXIL_DATA_W/2/1;  axil_rready_o  out  1  read data channel

Behaviour:
- Clock and reset: one clock, clk_i. Reset is arst_i, asynchronous and active-high.
- Reset values:
  - state IDLE, iob_ready_o=1.
  - All valid outputs 0; bready_o=0, rready_o=0.
  - iob_rdata_o=0; address and data registers 0.
- awprot_o and arprot_o are constant 3'b000.
- Accept: at a cycle T where avalid_i & ready_o & cke_i, the address, wdata and wstrb are captured into registers.
- States:
  - IDLE → WR if wstrb≠0, else → RD.
  - WR: awvalid_o=wvalid_o=1 from T+1. Each channel drops the cycle after its own valid&ready handshake; the two channels complete independently, in any order or simultaneously. When both are done → WB.
  - WB: bready_o=1. On bvalid_i → IDLE; bresp is ignored unless the optional feature is enabled. bready_o is never high before both AW and W have completed.
  - RD: arvalid_o=1 until arready_i, then rready_o=1. On rvalid_i: rdata is registered, iob_rvalid_o pulses for exactly one cycle, and the state → IDLE.
- iob_ready_o=1 only in IDLE, as a registered state decode.
- Minimum latency:
  - Write: slave ready immediately and bvalid next cycle → ready_o returns high at T+3.
  - Read: iob_rvalid_o at T+3, and ready_o is high in that same cycle.
- AXI rule: a valid output, once raised, is held, with its payload stable, until its handshake.
- cke_i=0 freezes all state, including the rvalid pulse. The pulse is held until the next enabled cycle.
- Reset mid-transaction: returns to IDLE immediately and drops all valids. Recovery of the AXI slave is the system's responsibility.
- ADDR_W<AXIL_ADDR_W: the upper address bits are driven 0.

Optional Feature:
- Macro: IOB2AXIL_ERR_EN.
- When defined, adds two ports:
  - err_o  out  1: sticky error flag.
  - err_clr_i  in  1: clears err_o.
- err_o is set the cycle after any bvalid or rvalid handshake with resp≠2'b00. It is cleared by err_clr_i. If set and clear occur in the same cycle, set wins. err_o resets to 0.
- When undefined, neither port exists and resp is ignored.

Decomposition:
- Shared header, iob_lib-style: state encodings IDLE/WR/WB/RD; AXI resp constants OKAY=2'b00, SLVERR=2'b10; the AXI-Lite master port include (iob_axil_m_port.vh), mirroring the existing slave include.
- No sub-module needed. Registers use the existing generic register with clk/cke/arst.

Test Plan:
- Write with zero-wait slave: addr 0x10, wdata 0xDEADBEEF, wstrb 0xF.
  - Required: aw/w valid at T+1 with payload unchanged; bready at T+2; ready_o=1 at T+3.
- Read with zero-wait slave: addr 0x20, slave rdata 0x12345678.
  - Required: iob_rvalid_o high for 1 cycle at T+3 with rdata 0x12345678; ready_o=1 the same cycle.
- Write with awready 3 cycles late and wready immediate.
  - Required: wvalid drops after T+1; awvalid held with stable payload until its handshake; no bready before both handshakes.
- Back-to-back read then write; slave asserts rvalid 5 cycles after arready.
  - Required: ready_o stays 0 throughout; the write is accepted only once IDLE is reached.
- arst_i pulsed while in WR with awvalid=1.
  - Required: all valids 0 and ready_o=1 asynchronously; the next transaction completes normally.
- IOB2AXIL_ERR_EN defined, read returning rresp=SLVERR.
  - Required: err_o=1 the next cycle and stays sticky.
  - A subsequent OKAY response leaves err_o=1; err_clr_i clears it.

Source files
------------

// File: rtl/iob2axil_pkg.sv
// Shared definitions for the IOb-to-AXI4-Lite bridge: FSM state encoding and AXI response codes.
package iob2axil_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        WB   = 2'd2,
        RD   = 2'd3
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/iob2axil.sv
// IOb slave to AXI4-Lite master bridge, one outstanding transaction, registered outputs.
// Optional sticky response-error flag enabled by defining IOB2AXIL_ERR_EN.
module iob2axil
    import iob2axil_pkg::*;
#(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32,
    parameter int ADDR_W      = AXIL_ADDR_W,
    parameter int DATA_W      = AXIL_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_i,
    input  logic                     iob_avalid_i,
    input  logic [ADDR_W-1:0]        iob_addr_i,
    input  logic [DATA_W-1:0]        iob_wdata_i,
    input  logic [DATA_W/8-1:0]      iob_wstrb_i,
    output logic                     iob_rvalid_o,
    output logic [DATA_W-1:0]        iob_rdata_o,
    output logic                     iob_ready_o,
    output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
    output logic [2:0]               axil_awprot_o,
    output logic                     axil_awvalid_o,
    input  logic                     axil_awready_i,
    output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
    output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
    output logic                     axil_wvalid_o,
    input  logic                     axil_wready_i,
    input  logic [1:0]               axil_bresp_i,
    input  logic                     axil_bvalid_i,
    output logic                     axil_bready_o,
    output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
    output logic [2:0]               axil_arprot_o,
    output logic                     axil_arvalid_o,
    input  logic                     axil_arready_i,
    input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
    input  logic [1:0]               axil_rresp_i,
    input  logic                     axil_rvalid_i,
`ifdef IOB2AXIL_ERR_EN
    output logic                     err_o,
    input  logic                     err_clr_i,
`endif
    output logic                     axil_rready_o
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W/8-1:0] wstrb_r;

    assign iob_ready_o    = (state == IDLE);
    assign axil_awaddr_o  = AXIL_ADDR_W'(addr_r);
    assign axil_araddr_o  = AXIL_ADDR_W'(addr_r);
    assign axil_wdata_o   = wdata_r;
    assign axil_wstrb_o   = wstrb_r;
    assign axil_awprot_o  = 3'b000;
    assign axil_arprot_o  = 3'b000;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state          <= IDLE;
            addr_r         <= '0;
            wdata_r        <= '0;
            wstrb_r        <= '0;
            axil_awvalid_o <= 1'b0;
            axil_wvalid_o  <= 1'b0;
            axil_bready_o  <= 1'b0;
            axil_arvalid_o <= 1'b0;
            axil_rready_o  <= 1'b0;
            iob_rvalid_o   <= 1'b0;
            iob_rdata_o    <= '0;
        end else if (cke_i) begin
            iob_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (iob_avalid_i) begin
                        addr_r  <= iob_addr_i;
                        wdata_r <= iob_wdata_i;
                        wstrb_r <= iob_wstrb_i;
                        if (|iob_wstrb_i) begin
                            state          <= WR;
                            axil_awvalid_o <= 1'b1;
                            axil_wvalid_o  <= 1'b1;
                        end else begin
                            state          <= RD;
                            axil_arvalid_o <= 1'b1;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; move on once both have handshaken.
                    if (axil_awready_i) axil_awvalid_o <= 1'b0;
                    if (axil_wready_i)  axil_wvalid_o  <= 1'b0;
                    if ((!axil_awvalid_o || axil_awready_i) &&
                        (!axil_wvalid_o  || axil_wready_i)) begin
                        state         <= WB;
                        axil_bready_o <= 1'b1;
                    end
                end
                WB: begin
                    if (axil_bvalid_i) begin
                        axil_bready_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                RD: begin
                    if (axil_arvalid_o) begin
                        if (axil_arready_i) begin
                            axil_arvalid_o <= 1'b0;
                            axil_rready_o  <= 1'b1;
                        end
                    end else if (axil_rvalid_i) begin
                        axil_rready_o <= 1'b0;
                        iob_rdata_o   <= axil_rdata_i;
                        iob_rvalid_o  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IOB2AXIL_ERR_EN
    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_o <= 1'b0;
        end else if (cke_i) begin
            err_o <= (err_o && !err_clr_i)
                   || (axil_bready_o && axil_bvalid_i && resp_err(axil_bresp_i))
                   || (axil_rready_o && axil_rvalid_i && resp_err(axil_rresp_i));
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{axil_bresp_i, axil_rresp_i};
`endif

endmodule
